// File: rtl/vfpu_job_sequencer.sv
`timescale 1ns/1ps
// Per-job sequencer for the vector FPU HWPE: launches the streamers once all are ready,
// counts accepted result beats and reports completion, length mismatches and stalls.
module vfpu_job_sequencer #(
  parameter int unsigned NB_OPERANDS    = 2,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   trans_size_i,
  input  logic [NB_OPERANDS-1:0] src_ready_start_i,
  input  logic [NB_OPERANDS-1:0] src_done_i,
  input  logic                   sink_ready_start_i,
  input  logic                   sink_done_i,
  input  logic                   res_valid_i,
  input  logic                   res_ready_i,
  output logic [NB_OPERANDS-1:0] src_req_start_o,
  output logic                   sink_req_start_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [CNT_WIDTH-1:0]   beat_cnt_o
);

  // state     | meaning
  // IDLE      | no job; waits for start
  // WAIT_RDY  | job accepted; waits for every streamer ready_start (size 0 skips to DONE)
  // LAUNCH    | one-cycle req_start to all streamers
  // RUN       | counting beats, collecting done pulses
  // DRAIN     | sink or all sources finished; waits for the rest
  // DONE      | one-cycle done pulse to the slave
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY = 3'd1;
  localparam logic [2:0] ST_LAUNCH   = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

  logic [2:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   size_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic [NB_OPERANDS-1:0] sd_q, sd_nxt;
  logic                   kd_q, kd_nxt;
  logic [STALL_W-1:0]     stall_q;
  logic                   err_q, err_set;
  logic                   beat, in_xfer, timeout_hit;

  assign beat        = res_valid_i & res_ready_i;
  assign in_xfer     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign sd_nxt      = sd_q | src_done_i;
  assign kd_nxt      = kd_q | sink_done_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (stall_q == STALL_LIMIT);

  always_comb begin
    cnt_nxt = cnt_q;
    if (in_xfer && beat && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_nxt = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = in_xfer && beat && (cnt_q >= size_q);
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (size_q == '0) begin
          state_d = ST_DONE;
        end else if ((&src_ready_start_i) && sink_ready_start_i) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (timeout_hit) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end else if (kd_nxt || (&sd_nxt)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (kd_q && (&sd_q)) begin
          state_d = ST_DONE;
          if (cnt_nxt != size_q) err_set = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      sd_q    <= '0;
      kd_q    <= 1'b0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      sd_q    <= '0;
      kd_q    <= 1'b0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_i) begin
        size_q  <= trans_size_i;
        cnt_q   <= '0;
        sd_q    <= '0;
        kd_q    <= 1'b0;
        stall_q <= '0;
        err_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        if (err_set) err_q <= 1'b1;
        if (in_xfer) begin
          sd_q <= sd_nxt;
          kd_q <= kd_nxt;
          if (beat) begin
            stall_q <= '0;
          end else if (stall_q != {STALL_W{1'b1}}) begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end else begin
          stall_q <= '0;
        end
      end
    end
  end

  assign src_req_start_o  = {NB_OPERANDS{state_q == ST_LAUNCH}};
  assign sink_req_start_o = (state_q == ST_LAUNCH);
  assign done_o           = (state_q == ST_DONE);
  assign busy_o           = (state_q != ST_IDLE);
  assign err_o            = err_q;
  assign beat_cnt_o       = cnt_q;

endmodule
